// File: rtl/xu0_dlmzb_stream_pkg.sv
// ---------------------------------------------------------------------------
// xu0_dlmzb_stream_pkg
// Shared definitions for the dlmzb streaming scanner: FSM state encoding,
// the legal beat widths, and the width of the per-beat zero index.
// ---------------------------------------------------------------------------
package xu0_dlmzb_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal values for bytes per input beat.
    localparam int BPB_NARROW = 4;
    localparam int BPB_WIDE   = 8;

    // Holds a 1-based byte index up to BPB_WIDE.
    localparam int IDX_W = 4;

    function automatic logic bpb_is_legal(input int bpb);
        return (bpb == BPB_NARROW) || (bpb == BPB_WIDE);
    endfunction

endpackage

// File: rtl/xu0_dlmzb_stream_if.sv
// ---------------------------------------------------------------------------
// xu0_dlmzb_stream_if
// Beat input channel and result output channel of the dlmzb scanner.
//   in_val/in_rdy/in_last/in_data/in_xer : string beats toward the scanner
//   out_val/out_rdy/out_xer/out_cr/out_rt: one result per string
// Bit vectors use big-endian numbering: byte 0 of in_data is bits [0:7].
// Modports: master = beat producer / result consumer, slave = scanner.
// ---------------------------------------------------------------------------
interface xu0_dlmzb_stream_if #(
    parameter int BPB  = 4,
    parameter int CNTW = 7
);
    logic              in_val;
    logic              in_last;
    logic [0:8*BPB-1]  in_data;
    logic [0:2]        in_xer;
    logic              in_rdy;
    logic              out_val;
    logic              out_rdy;
    logic [0:CNTW+2]   out_xer;
    logic [0:3]        out_cr;
    logic [0:CNTW-1]   out_rt;

    modport master (
        output in_val, in_last, in_data, in_xer, out_rdy,
        input  in_rdy, out_val, out_xer, out_cr, out_rt
    );

    modport slave (
        input  in_val, in_last, in_data, in_xer, out_rdy,
        output in_rdy, out_val, out_xer, out_cr, out_rt
    );
endinterface

// File: rtl/xu0_dlmzb_beat.sv
// ---------------------------------------------------------------------------
// xu0_dlmzb_beat
// Combinational scan of one beat for its leftmost zero byte.
//   data       : beat, byte 0 = bits [0:7]
//   zero_found : some byte of the beat is 0x00
//   zero_idx   : 1-based index of the leftmost zero byte (0 when none)
// ---------------------------------------------------------------------------
module xu0_dlmzb_beat
    import xu0_dlmzb_stream_pkg::*;
#(
    parameter int BPB = 4
) (
    input  logic [0:8*BPB-1] data,
    output logic             zero_found,
    output logic [IDX_W-1:0] zero_idx
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        zero_found = 1'b0;
        zero_idx   = '0;
        // Walk right to left so the leftmost zero byte is the last writer.
        for (int i = BPB - 1; i >= 0; i--) begin
            if (data[8*i +: 8] == 8'h00) begin
                zero_found = 1'b1;
                zero_idx   = IDX_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/xu0_dlmzb_stream.sv
// ---------------------------------------------------------------------------
// xu0_dlmzb_stream
// Streaming "determine leftmost zero byte": scans a string delivered as
// BPB-byte beats, counts bytes up to and including the first 0x00 (or all
// bytes when none), and returns one result carrying XER and a CR field.
//   nclk  : clock (rising edge)
//   rst   : synchronous active-high reset
//   flush : abandon the current scan / result
//   bus   : xu0_dlmzb_stream_if.slave (beats in, result out)
// Build option: define XU_DLMZB_CNT_SAT_EN to saturate the byte count at
// 2^CNTW-1; otherwise it wraps modulo 2^CNTW.
// BPB must be 4 or 8 (see bpb_is_legal in the package).
// ---------------------------------------------------------------------------
module xu0_dlmzb_stream
    import xu0_dlmzb_stream_pkg::*;
#(
    parameter int BPB  = 4,
    parameter int CNTW = 7
) (
    input  logic                 nclk,
    input  logic                 rst,
    input  logic                 flush,
    xu0_dlmzb_stream_if.slave    bus
);

    state_t            state_q, state_d;
    logic [CNTW-1:0]   count_q, count_next;
    logic              found_q;
    logic              first_hit_q;
    logic [0:2]        xer_q;

    logic              beat_found;
    logic [IDX_W-1:0]  beat_idx;
    logic              accept;
    logic [CNTW-1:0]   base;
    logic [CNTW-1:0]   inc;

    xu0_dlmzb_beat #(.BPB(BPB)) u_beat (
        .data       (bus.in_data),
        .zero_found (beat_found),
        .zero_idx   (beat_idx)
    );

    // Ready is withheld while reset or flush is applied so a beat offered in
    // that cycle is never consumed.
    assign bus.in_rdy = ~rst & ~flush & (state_q != DONE);
    assign accept     = bus.in_val & bus.in_rdy;

    // A beat taken in IDLE starts a new string, so its count starts from 0.
    always_comb begin
        base = (state_q == IDLE) ? '0 : count_q;
        inc  = beat_found ? CNTW'(beat_idx) : CNTW'(BPB);
    end

`ifdef XU_DLMZB_CNT_SAT_EN
    logic [CNTW:0] sum;
    always_comb begin
        sum        = {1'b0, base} + {1'b0, inc};
        count_next = sum[CNTW] ? '1 : sum[CNTW-1:0];
    end
`else
    always_comb begin
        count_next = base + inc;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = bus.in_last ? DONE : SCAN;
            SCAN: begin
                if (flush)                      state_d = IDLE;
                else if (accept && bus.in_last) state_d = DONE;
            end
            DONE: if (flush || bus.out_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge nclk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: all scan registers are reset (a handful of flops, not a memory),
    // so a result after reset never carries stale count, flags or XER.
    always_ff @(posedge nclk) begin
        if (rst) begin
            count_q     <= '0;
            found_q     <= 1'b0;
            first_hit_q <= 1'b0;
            xer_q       <= '0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                xer_q       <= bus.in_xer;
                count_q     <= count_next;
                found_q     <= beat_found;
                first_hit_q <= beat_found;
            end else if (!found_q) begin
                count_q <= count_next;
                found_q <= beat_found;
            end
            // Once found, remaining beats are drained without touching count.
        end
    end

    assign bus.out_val = (state_q == DONE);
    assign bus.out_xer = bus.out_val ? {xer_q, count_q} : '0;
    assign bus.out_rt  = bus.out_val ? count_q : '0;
    assign bus.out_cr  = bus.out_val ? {found_q & ~first_hit_q, found_q & first_hit_q,
                                        ~found_q, xer_q[0]} : '0;

endmodule

// File: tb/tb_xu0_dlmzb_stream.sv
// ---------------------------------------------------------------------------
// tb_xu0_dlmzb_stream
// Scoreboard bench for xu0_dlmzb_stream. Each string's expected result is
// derived from its flat byte list and pushed when the string is issued; a
// monitor pops and compares whenever the scanner presents a result.
// ---------------------------------------------------------------------------
module tb_xu0_dlmzb_stream;
    import xu0_dlmzb_stream_pkg::*;

    localparam int BPB  = 4;
    localparam int CNTW = 7;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [0:CNTW+2] xer;
        logic [0:3]      cr;
        logic [0:CNTW-1] rt;
    } exp_t;

    logic nclk = 1'b0;
    logic rst;
    logic flush;

    always #5 nclk = ~nclk;

    xu0_dlmzb_stream_if #(.BPB(BPB), .CNTW(CNTW)) bus ();

    xu0_dlmzb_stream #(.BPB(BPB), .CNTW(CNTW)) dut (
        .nclk  (nclk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   stall_min = 0;
    logic holding = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: count bytes up to and including the first zero of the whole
    // string, otherwise all bytes; then wrap or saturate to CNTW bits.
    function automatic exp_t model(input bq_t bytes, input logic [0:2] xer);
        exp_t e;
        int   pos = -1;
        longint cnt;
        logic found, first_hit;
        for (int i = 0; i < bytes.size(); i++)
            if (bytes[i] == 8'h00 && pos < 0) pos = i;
        found     = (pos >= 0);
        first_hit = found && (pos < BPB);
        cnt       = found ? longint'(pos + 1) : longint'(bytes.size());
`ifdef XU_DLMZB_CNT_SAT_EN
        if (cnt > (2**CNTW - 1)) cnt = 2**CNTW - 1;
`else
        cnt = cnt % (2**CNTW);
`endif
        e.rt  = CNTW'(cnt);
        e.xer = {xer, CNTW'(cnt)};
        e.cr  = {found & ~first_hit, found & first_hit, ~found, xer[0]};
        return e;
    endfunction

    // Monitor: compares each result on first presentation, checks it holds
    // steady while stalled, and drives out_rdy with a random back-pressure.
    exp_t cur;
    int   seen = 0;
    always @(negedge nclk) begin
        if (rst) begin
            bus.out_rdy = 1'b0;
            holding     = 1'b0;
        end else begin
            if (holding && bus.out_rdy) begin
                check("no_double_result", {63'd0, bus.out_val}, 64'd0);
                holding     = 1'b0;
                bus.out_rdy = 1'b0;
            end
            if (bus.out_val) begin
                check("in_rdy_low_in_done", {63'd0, bus.in_rdy}, 64'd0);
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", {63'd0, bus.out_val}, 64'd0);
                        cur.xer = bus.out_xer;
                        cur.cr  = bus.out_cr;
                        cur.rt  = bus.out_rt;
                    end else begin
                        cur = exp_q.pop_front();
                        check("result_xer", 64'(bus.out_xer), 64'(cur.xer));
                        check("result_cr",  64'(bus.out_cr),  64'(cur.cr));
                        check("result_rt",  64'(bus.out_rt),  64'(cur.rt));
                    end
                    holding = 1'b1;
                    seen    = 0;
                end else begin
                    check("stable_xer", 64'(bus.out_xer), 64'(cur.xer));
                    check("stable_cr",  64'(bus.out_cr),  64'(cur.cr));
                end
                seen++;
                bus.out_rdy = (seen > stall_min) && ($urandom_range(0, 2) != 0);
            end else begin
                holding     = 1'b0;
                bus.out_rdy = 1'b0;
                check("idle_out_zero", 64'({bus.out_xer, bus.out_cr, bus.out_rt}), 64'd0);
            end
        end
    end

    // Offer one beat and hold it until the scanner accepts it.
    task automatic drive_beat(input logic [0:8*BPB-1] d, input logic last, input logic [0:2] x);
        int w = 0;
        bus.in_val  = 1'b1;
        bus.in_last = last;
        bus.in_data = d;
        bus.in_xer  = x;
        @(negedge nclk);
        while (!bus.in_rdy && w < 200) begin
            w++;
            @(negedge nclk);
        end
        if (w >= 200) check("in_rdy_timeout", 64'd0, 64'd1);
        @(posedge nclk);
        #1;
        bus.in_val  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic send_string(input bq_t bytes, input logic [0:2] xer, input int max_gap);
        int nb = bytes.size() / BPB;
        logic [0:8*BPB-1] d;
        logic [0:2] x;
        exp_q.push_back(model(bytes, xer));
        for (int b = 0; b < nb; b++) begin
            int gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                @(posedge nclk);
                #1;
            end
            for (int j = 0; j < BPB; j++) d[8*j +: 8] = bytes[b*BPB + j];
            // XER on later beats is noise; only the first beat's value counts.
            x = (b == 0) ? xer : 3'($urandom_range(0, 7));
            drive_beat(d, b == nb - 1, x);
        end
        @(negedge nclk);
        check("result_latency", {63'd0, bus.out_val}, 64'd1);
        @(posedge nclk);
        #1;
    endtask

    function automatic bq_t words_to_bytes(input logic [31:0] w[$]);
        bq_t q;
        for (int i = 0; i < w.size(); i++)
            for (int j = 3; j >= 0; j--) q.push_back(w[i][8*j +: 8]);
        return q;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || holding) && n < 2000) begin
            @(posedge nclk);
            n++;
        end
        #1;
        check("drain_results", 64'(exp_q.size()), 64'd0);
    endtask

    // Abandon a two-beat partial string with flush (use_rst=0) or rst
    // (use_rst=1) while a terminating beat is offered in the same cycle.
    task automatic abort_scan(input logic use_rst, input string tag);
        drive_beat(32'h41424344, 1'b0, 3'b111);
        drive_beat(32'h45464748, 1'b0, 3'b000);
        bus.in_val  = 1'b1;
        bus.in_last = 1'b1;
        bus.in_data = 32'h00000000;
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(posedge nclk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        bus.in_val = 1'b0;
        bus.in_last = 1'b0;
        @(negedge nclk);
        check({tag, "_out_val"}, {63'd0, bus.out_val}, 64'd0);
        check({tag, "_in_rdy"},  {63'd0, bus.in_rdy},  64'd1);
        repeat (4) @(posedge nclk);
        #1;
        // The next string must count from 0: zero byte at index 1 -> count 2.
        send_string(words_to_bytes('{32'h55006677}), 3'b010, 0);
        wait_idle();
    endtask

    initial begin
        bq_t q;
        logic [31:0] w[$];
        rst         = 1'b1;
        flush       = 1'b0;
        bus.in_val  = 1'b1;
        bus.in_last = 1'b1;
        bus.in_data = '0;
        bus.in_xer  = 3'b111;
        repeat (3) @(posedge nclk);
        #1;
        rst        = 1'b0;
        bus.in_val = 1'b0;
        bus.in_last = 1'b0;
        @(negedge nclk);
        check("reset_out_val", {63'd0, bus.out_val}, 64'd0);
        check("reset_in_rdy",  {63'd0, bus.in_rdy},  64'd1);
        check("reset_out_xer", 64'(bus.out_xer), 64'd0);
        @(posedge nclk);
        #1;

        // Zero in the first beat, SO set: count 3, cr 0101, xer 1000000011.
        send_string(words_to_bytes('{32'h41420043}), 3'b100, 0);
        wait_idle();
        // Zero in the second beat: count 6, cr 1000.
        send_string(words_to_bytes('{32'h41424344, {16'h4100, 16'($urandom)}}), 3'b011, 1);
        // No zero at all: count 8, cr 0010.
        send_string(words_to_bytes('{32'h41424344, 32'h45464748}), 3'b001, 1);
        wait_idle();

        // 33 non-zero beats: the count wraps or saturates past 127.
        w = {};
        for (int i = 0; i < 33; i++) w.push_back(32'h01020304 + 32'(i));
        send_string(words_to_bytes(w), 3'b110, 0);
        wait_idle();

        // Five stalled cycles while the result is held.
        stall_min = 5;
        send_string(words_to_bytes('{32'h7F7F7F00, 32'h00112233}), 3'b101, 0);
        wait_idle();
        stall_min = 0;

        abort_scan(1'b0, "flush");
        abort_scan(1'b1, "rst");

        // Random strings: 1..5 beats, sparse zeros, random gaps and stalls.
        for (int s = 0; s < 40; s++) begin
            int nb = $urandom_range(1, 5);
            q = {};
            for (int i = 0; i < nb * BPB; i++)
                q.push_back(($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
            send_string(q, 3'($urandom_range(0, 7)), 2);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xu0_dlmzb_stream.md
XU0_DLMZB_STREAM -- requirements
Module: xu0_dlmzb_stream

Interface
REQ-001 SHALL have parameter BPB, default 4: bytes per input beat (legal 4 or 8).
REQ-002 SHALL have parameter CNTW, default 7: width of the byte-count field.
REQ-003 SHALL have port nclk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: abandon the current scan.
REQ-006 SHALL have port in_val, input, 1: beat valid.
REQ-007 SHALL have port in_last, input, 1: final beat of the string.
REQ-008 SHALL have port in_data, input, [0:8*BPB-1]: beat data; byte 0 = bits [0:7], scanned first.
REQ-009 SHALL have port in_xer, input, [0:2]: SO, OV, CA, sampled on the first beat only.
REQ-010 SHALL have port in_rdy, output, 1: beat accepted when in_val & in_rdy.
REQ-011 SHALL have port out_val, output, 1: result valid.
REQ-012 SHALL have port out_rdy, input, 1: result consumed when out_val & out_rdy.
REQ-013 SHALL have port out_xer, output, [0:CNTW+2]: {SO, OV, CA, count}.
REQ-014 SHALL have port out_cr, output, [0:3]: CR field.
REQ-015 SHALL have port out_rt, output, [0:CNTW-1]: count (the RT low-order bits).

Function
REQ-016 SHALL implement states IDLE, SCAN and DONE.
REQ-017 SHALL assert in_rdy in IDLE and SCAN only; in_rdy SHALL be 0 in DONE.
REQ-018 On a beat accepted in IDLE, SHALL capture in_xer, clear found, and go to SCAN (or to DONE if in_last).
REQ-019 Per accepted beat while not found, SHALL locate the leftmost zero byte index k and set count += k+1 and found=1 if one exists, else count += BPB.
REQ-020 Once found=1, SHALL keep accepting beats (drain) without changing count until in_last.
REQ-021 SHALL record first_hit=1 when the zero byte lies in the first beat of the string.
REQ-022 On accepting an in_last beat, SHALL enter DONE and assert out_val on the next cycle (latency 1).
REQ-023 In DONE, outputs SHALL stay stable until out_rdy=1; then the block SHALL return to IDLE, with in_rdy=0 in that same cycle (no bypass).
REQ-024 out_cr SHALL be {found & ~first_hit, found & first_hit, ~found, SO}.
REQ-025 out_xer SHALL be {SO, OV, CA, count}, and out_rt SHALL be count.
REQ-026 flush in SCAN or DONE SHALL return to IDLE next cycle and drop out_val; any beat offered in that cycle SHALL be ignored.
REQ-027 out_xer, out_cr and out_rt SHALL be 0 whenever out_val=0.

Reset
REQ-028 rst SHALL force IDLE, out_val=0, count=0, found=0, first_hit=0 and captured XER=0 at the next edge, including mid-scan or in DONE.
REQ-029 rst SHALL take priority over flush, in_val and out_rdy.

Configuration
REQ-030 With macro XU_DLMZB_CNT_SAT_EN defined, count SHALL saturate at 2^CNTW-1.
REQ-031 Without XU_DLMZB_CNT_SAT_EN, count SHALL wrap modulo 2^CNTW.

Structure
REQ-032 A shared package SHALL hold the state encoding (IDLE=0, SCAN=1, DONE=2) and the legal BPB constants.
REQ-033 A combinational sub-module xu0_dlmzb_beat SHALL, for one beat, return the zero-found flag and the 1-based index of the leftmost zero byte.

Verification
REQ-034 BPB=4, one beat 0x41420043, in_last=1, in_xer=100 -> out_val next cycle, count=3, cr=0101, xer=1000000011.
REQ-035 Beats 0x41424344 then 0x4100xxxx (last) -> count=6, cr=1000.
REQ-036 Beats 0x41424344 then 0x45464748 (last) -> count=8, cr=0010.
REQ-037 33 non-zero 4-byte beats, with XU_DLMZB_CNT_SAT_EN -> count=127; without it -> count=4 (132 mod 128).
REQ-038 out_rdy held low for 5 cycles in DONE -> outputs stable and in_rdy=0 throughout; after out_rdy, IDLE with no double result.
REQ-039 rst or flush asserted mid-SCAN -> IDLE next cycle, out_val never asserted, next string scanned from count=0.
